// File: rtl/score_controller.sv
// Pong score sequencer: counts points per player, freezes the ball for a
// fixed hold time after every point, detects the winning score and then
// blinks the winner's digit until a new game is requested.
module score_controller #(
    parameter int WIN_SCORE    = 9,
    parameter int HOLD_CYCLES  = 25_000_000,
    parameter int BLINK_CYCLES = 12_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p1_point,
    input  logic       p2_point,
    input  logic       new_game,
    output logic [3:0] p1score,
    output logic [3:0] p2score,
    output logic       ball_freeze,
    output logic       serve_dir,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
    localparam logic [3:0]    WIN        = 4'(WIN_SCORE);
    // Digit code that scoreDisplay renders as an unlit digit.
    localparam logic [3:0]    BLANK_CODE = 4'd10;

    typedef enum logic [1:0] {
        PLAY,
        HOLD,
        GAME_OVER
    } state_t;

    state_t        state;
    logic [3:0]    s1;
    logic [3:0]    s2;
    logic [HW-1:0] hold_cnt;
    logic [BW-1:0] blink_cnt;
    logic          blank;

    logic [3:0]    s1_inc;
    logic [3:0]    s2_inc;

    assign s1_inc = s1 + 4'd1;
    assign s2_inc = s2 + 4'd1;

    // Single state machine; every output is a register updated alongside state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= HOLD;
            s1          <= 4'd0;
            s2          <= 4'd0;
            hold_cnt    <= '0;
            blink_cnt   <= '0;
            blank       <= 1'b0;
            p1score     <= 4'd0;
            p2score     <= 4'd0;
            ball_freeze <= 1'b1;
            serve_dir   <= 1'b0;
            game_over   <= 1'b0;
            winner      <= 2'b00;
        end else if (new_game) begin
            // Restart wins over any point pulse arriving in the same cycle.
            state       <= HOLD;
            s1          <= 4'd0;
            s2          <= 4'd0;
            hold_cnt    <= '0;
            blink_cnt   <= '0;
            blank       <= 1'b0;
            p1score     <= 4'd0;
            p2score     <= 4'd0;
            ball_freeze <= 1'b1;
            serve_dir   <= 1'b0;
            game_over   <= 1'b0;
            winner      <= 2'b00;
        end else begin
            case (state)
                PLAY: begin
                    if (p1_point && p2_point) begin
                        // Simultaneous points: replay without scoring.
                        state       <= HOLD;
                        hold_cnt    <= '0;
                        ball_freeze <= 1'b1;
                    end else if (p1_point && (s1 < WIN)) begin
                        s1          <= s1_inc;
                        p1score     <= s1_inc;
                        serve_dir   <= 1'b1;
                        ball_freeze <= 1'b1;
                        if (s1_inc == WIN) begin
                            state     <= GAME_OVER;
                            game_over <= 1'b1;
                            winner    <= 2'b01;
                            blink_cnt <= '0;
                            blank     <= 1'b0;
                        end else begin
                            state    <= HOLD;
                            hold_cnt <= '0;
                        end
                    end else if (p2_point && (s2 < WIN)) begin
                        s2          <= s2_inc;
                        p2score     <= s2_inc;
                        serve_dir   <= 1'b0;
                        ball_freeze <= 1'b1;
                        if (s2_inc == WIN) begin
                            state     <= GAME_OVER;
                            game_over <= 1'b1;
                            winner    <= 2'b10;
                            blink_cnt <= '0;
                            blank     <= 1'b0;
                        end else begin
                            state    <= HOLD;
                            hold_cnt <= '0;
                        end
                    end
                end
                HOLD: begin
                    // Point pulses are ignored while the ball is parked.
                    if (hold_cnt == HOLD_LAST) begin
                        state       <= PLAY;
                        hold_cnt    <= '0;
                        ball_freeze <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                GAME_OVER: begin
                    // Toggle the blank flag every BLINK_CYCLES; only the winner's digit blinks.
                    if (blink_cnt == BLINK_LAST) begin
                        blink_cnt <= '0;
                        blank     <= ~blank;
                        if (winner == 2'b01) begin
                            p1score <= blank ? s1 : BLANK_CODE;
                        end else begin
                            p2score <= blank ? s2 : BLANK_CODE;
                        end
                    end else begin
                        blink_cnt <= blink_cnt + 1'b1;
                    end
                end
                default: begin
                    state       <= HOLD;
                    hold_cnt    <= '0;
                    ball_freeze <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_controller.sv
// Bench for score_controller with WIN_SCORE=3, HOLD_CYCLES=4, BLINK_CYCLES=3.
// Expected output words are queued before each scenario runs and popped as
// the DUT produces each cycle's outputs.
module tb_score_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       p1_point = 1'b0;
    logic       p2_point = 1'b0;
    logic       new_game = 1'b0;
    logic [3:0] p1score;
    logic [3:0] p2score;
    logic       ball_freeze;
    logic       serve_dir;
    logic       game_over;
    logic [1:0] winner;

    int errors = 0;
    int checks = 0;

    // Output word layout: {p1score, p2score, ball_freeze, serve_dir, game_over, winner}
    logic [12:0] sb[$];
    logic [12:0] obs;
    logic [12:0] exp_v;

    assign obs = {p1score, p2score, ball_freeze, serve_dir, game_over, winner};

    score_controller #(
        .WIN_SCORE   (3),
        .HOLD_CYCLES (4),
        .BLINK_CYCLES(3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .p1_point   (p1_point),
        .p2_point   (p2_point),
        .new_game   (new_game),
        .p1score    (p1score),
        .p2score    (p2score),
        .ball_freeze(ball_freeze),
        .serve_dir  (serve_dir),
        .game_over  (game_over),
        .winner     (winner)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] pack(input logic [3:0] a, input logic [3:0] b,
                                         input logic bf, input logic sd,
                                         input logic go, input logic [1:0] w);
        return {a, b, bf, sd, go, w};
    endfunction

    // Drive inputs for one clock edge, then sample point is 1 time unit after it.
    task automatic step(input logic a, input logic b, input logic ng);
        p1_point = a;
        p2_point = b;
        new_game = ng;
        @(posedge clk);
        #1;
        p1_point = 1'b0;
        p2_point = 1'b0;
        new_game = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sb.push_back(pack(4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 2'b00));
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_held: got %b want %b", obs, exp_v);
        end else $display("check reset_held got %b", obs);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) sb.push_back(pack(4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 2'b00));
        sb.push_back(pack(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00));
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_release[%0d]: got %b want %b", i, obs, exp_v);
            end else $display("check reset_release[%0d] got %b", i, obs);
        end
    endtask

    task automatic test_p1_point();
        for (int i = 0; i < 4; i++) sb.push_back(pack(4'd1, 4'd0, 1'b1, 1'b1, 1'b0, 2'b00));
        sb.push_back(pack(4'd1, 4'd0, 1'b0, 1'b1, 1'b0, 2'b00));
        for (int i = 0; i < 5; i++) begin
            // p2_point during HOLD (i==2) must be ignored.
            step(i == 0, i == 2, 1'b0);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL p1_point[%0d]: got %b want %b", i, obs, exp_v);
            end else $display("check p1_point[%0d] got %b", i, obs);
        end
    endtask

    task automatic test_let();
        for (int i = 0; i < 4; i++) sb.push_back(pack(4'd1, 4'd0, 1'b1, 1'b1, 1'b0, 2'b00));
        sb.push_back(pack(4'd1, 4'd0, 1'b0, 1'b1, 1'b0, 2'b00));
        for (int i = 0; i < 5; i++) begin
            step(i == 0, i == 0, 1'b0);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL let[%0d]: got %b want %b", i, obs, exp_v);
            end else $display("check let[%0d] got %b", i, obs);
        end
    endtask

    task automatic test_p2_win();
        for (int pt = 1; pt <= 2; pt++) begin
            for (int i = 0; i < 4; i++) sb.push_back(pack(4'd1, 4'(pt), 1'b1, 1'b0, 1'b0, 2'b00));
            sb.push_back(pack(4'd1, 4'(pt), 1'b0, 1'b0, 1'b0, 2'b00));
            for (int i = 0; i < 5; i++) begin
                step(1'b0, i == 0, 1'b0);
                exp_v = sb.pop_front();
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL p2_point%0d[%0d]: got %b want %b", pt, i, obs, exp_v);
                end else $display("check p2_point%0d[%0d] got %b", pt, i, obs);
            end
        end
        // Winning point: winner digit visible 3 cycles, blank 3 cycles, repeating.
        for (int i = 0; i < 9; i++)
            sb.push_back(pack(4'd1, (((i / 3) % 2) == 1) ? 4'd10 : 4'd3, 1'b1, 1'b0, 1'b1, 2'b10));
        for (int i = 0; i < 9; i++) begin
            step(1'b0, (i == 0) || (i == 4), 1'b0);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL p2_win_blink[%0d]: got %b want %b", i, obs, exp_v);
            end else $display("check p2_win_blink[%0d] got %b", i, obs);
        end
    endtask

    task automatic test_new_game();
        for (int i = 0; i < 4; i++) sb.push_back(pack(4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 2'b00));
        sb.push_back(pack(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00));
        for (int i = 0; i < 5; i++) begin
            step(i == 0, 1'b0, i == 0);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL new_game[%0d]: got %b want %b", i, obs, exp_v);
            end else $display("check new_game[%0d] got %b", i, obs);
        end
    endtask

    task automatic test_reset_mid_hold();
        for (int i = 0; i < 3; i++) sb.push_back(pack(4'd1, 4'd0, 1'b1, 1'b1, 1'b0, 2'b00));
        for (int i = 0; i < 3; i++) begin
            step(i == 0, 1'b0, 1'b0);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL mid_hold_pre[%0d]: got %b want %b", i, obs, exp_v);
            end else $display("check mid_hold_pre[%0d] got %b", i, obs);
        end
        // Hold counter is now 2; assert reset between clock edges.
        #1 reset = 1'b0;
        #1;
        sb.push_back(pack(4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 2'b00));
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL mid_hold_async: got %b want %b", obs, exp_v);
        end else $display("check mid_hold_async got %b", obs);
        @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 3; i++) sb.push_back(pack(4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 2'b00));
        sb.push_back(pack(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00));
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL mid_hold_release[%0d]: got %b want %b", i, obs, exp_v);
            end else $display("check mid_hold_release[%0d] got %b", i, obs);
        end
    endtask

    task automatic test_reset_mid_gameover();
        for (int pt = 1; pt <= 2; pt++) begin
            for (int i = 0; i < 4; i++) sb.push_back(pack(4'(pt), 4'd0, 1'b1, 1'b1, 1'b0, 2'b00));
            sb.push_back(pack(4'(pt), 4'd0, 1'b0, 1'b1, 1'b0, 2'b00));
            for (int i = 0; i < 5; i++) begin
                step(i == 0, 1'b0, 1'b0);
                exp_v = sb.pop_front();
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL p1_point%0d[%0d]: got %b want %b", pt, i, obs, exp_v);
                end else $display("check p1_point%0d[%0d] got %b", pt, i, obs);
            end
        end
        for (int i = 0; i < 4; i++)
            sb.push_back(pack((i == 3) ? 4'd10 : 4'd3, 4'd0, 1'b1, 1'b1, 1'b1, 2'b01));
        for (int i = 0; i < 4; i++) begin
            step(i == 0, 1'b0, 1'b0);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL p1_win_blink[%0d]: got %b want %b", i, obs, exp_v);
            end else $display("check p1_win_blink[%0d] got %b", i, obs);
        end
        // Winner digit is blanked now; reset asynchronously.
        #1 reset = 1'b0;
        #1;
        sb.push_back(pack(4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 2'b00));
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL mid_gameover_async: got %b want %b", obs, exp_v);
        end else $display("check mid_gameover_async got %b", obs);
        @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 3; i++) sb.push_back(pack(4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 2'b00));
        sb.push_back(pack(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00));
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL mid_gameover_release[%0d]: got %b want %b", i, obs, exp_v);
            end else $display("check mid_gameover_release[%0d] got %b", i, obs);
        end
    endtask

    initial begin
        test_reset();
        test_p1_point();
        test_let();
        test_p2_win();
        test_new_game();
        test_reset_mid_hold();
        test_reset_mid_gameover();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/score_controller.md
Name: score_controller

Overview:
- Pong game-score sequencer: counts points per player, freezes play after each point, detects the win, then blinks the winner's digit.
- Sits between the ball/paddle collision logic (point pulses in) and scoreDisplay (4-bit score codes out, value 10 = blank digit).
- Also owns the serve direction and ball-freeze handshake for the ball engine.

Parameters:
- WIN_SCORE, 9, points needed to win; legal range 1..9 (single decimal digit).
- HOLD_CYCLES, 25_000_000, clk cycles the ball stays frozen after a point (0.5 s at 50 MHz); must be >= 1.
- BLINK_CYCLES, 12_500_000, clk cycles per blink half-period of the winner digit in GAME_OVER; must be >= 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- p1_point  in  1  single-cycle pulse: player 1 scored.
- p2_point  in  1  single-cycle pulse: player 2 scored.
- new_game  in  1  single-cycle pulse: restart from 0–0.
- p1score  out  4  player 1 digit code to scoreDisplay; 0..9, or 10 for blank.
- p2score  out  4  player 2 digit code to scoreDisplay; 0..9, or 10 for blank.
- ball_freeze  out  1  high = ball engine must hold the ball at centre.
- serve_dir  out  1  0 = serve toward player 1, 1 = serve toward player 2.
- game_over  out  1  high while in GAME_OVER.
- winner  out  2  00 = none, 01 = player 1, 10 = player 2.

Behaviour:
- All outputs are registered. Reset (reset=0) asynchronously forces the following, whenever asserted, including mid-HOLD or mid-GAME_OVER:
  - state=HOLD, both scores 0, p1score=p2score=0;
  - ball_freeze=1, serve_dir=0, game_over=0, winner=00;
  - hold and blink counters cleared.
- States: PLAY, HOLD, GAME_OVER.
- PLAY:
  - ball_freeze=0.
  - p1_point alone: s1<=s1+1; serve_dir<=1 (loser serves... ball goes toward the scorer's opponent, i.e. player 2).
  - p2_point alone: s2<=s2+1; serve_dir<=0.
  - Both pulses in the same cycle: treated as a let. No score change, serve_dir unchanged, go to HOLD.
  - After an accepted point: if the new score equals WIN_SCORE, go to GAME_OVER; else go to HOLD.
  - ball_freeze rises 1 cycle after the point pulse, in the same cycle the score output updates.
- HOLD:
  - ball_freeze=1; hold counter counts 0..HOLD_CYCLES-1, then go to PLAY with the counter cleared.
  - Exactly HOLD_CYCLES cycles are spent in HOLD.
  - Point pulses in HOLD are ignored.
- GAME_OVER:
  - ball_freeze=1, game_over=1, winner set.
  - Point pulses are ignored. Scores are saturated and never exceed WIN_SCORE; no wrap.
  - Blink counter counts 0..BLINK_CYCLES-1, then toggles a blank flag.
  - Blank flag starts 0 on entry, so the digit is visible first.
  - While blank=1, the winner's output digit=10; the loser's digit always shows its score.
- new_game (any state, reset high):
  - next cycle: scores 0, winner=00, game_over=0, blink state cleared, state=HOLD, hold counter cleared, serve_dir=0.
  - new_game has priority over a point pulse in the same cycle.
- Score width: internal scores are 4 bits. Increment only from PLAY, and only when below WIN_SCORE, so values 10..15 are unreachable.
- Counters are sized to $clog2 of their parameter, minimum 1 bit.
- After reset release: HOLD for HOLD_CYCLES, then PLAY.

Test Plan (sim params WIN_SCORE=3, HOLD_CYCLES=4, BLINK_CYCLES=3):
- Reset held low 3 cycles, then released → outputs 0/0, ball_freeze=1 for exactly 4 cycles, then 0; winner=00.
- In PLAY, pulse p1_point → next cycle p1score=1, serve_dir=1, ball_freeze=1 for 4 cycles; p2_point pulsed during HOLD → p2score stays 0.
- In PLAY, pulse p1_point and p2_point in the same cycle → scores unchanged, serve_dir unchanged, HOLD entered (ball_freeze=1 for 4 cycles).
- Drive p2 to 3 points → game_over=1, winner=10, p2score shows 3 for 3 cycles, 10 for 3 cycles, repeating; p1score steady; further p2_point leaves p2score ≤3.
- In GAME_OVER, pulse new_game together with p1_point → next cycle scores 0/0, game_over=0, winner=00, HOLD for 4 cycles.
- Assert reset mid-HOLD (counter=2) and mid-GAME_OVER blank phase → outputs immediately (asynchronously) 0/0, blank cleared, full 4-cycle HOLD after release.
